gpio_input_filter: RTL and testbench

Conditions raw asynchronous pad inputs before they reach the GPIO device's `gpio_input` port. Each pin gets a two-flop synchronizer, an optional per-pin debounce filter timed by a shared prescaler, and rise/fall edge detection into sticky interrupt-pending flags. It sits between the pad ring and the GPIO device. Configuration comes from neighbouring configuration registers as plain ports.

---
 rtl/gpio_input_filter_pkg.sv | 29 ++
 rtl/gpio_input_channel.sv | 98 +++++++++
 rtl/gpio_input_filter.sv | 71 +++++++
 tb/tb_gpio_input_filter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_input_filter_pkg.sv
// Shared constants and types for the GPIO input conditioning path.
// Consumed by gpio_input_filter and gpio_input_channel.
package gpio_input_filter_pkg;

  localparam int DEFAULT_IO_COUNT       = 16;
  localparam int DEFAULT_PRESCALE_WIDTH = 8;
  localparam int DEFAULT_DEBOUNCE_WIDTH = 4;

  localparam int SYNC_STAGES = 2;

  // Edge encodings shared with the downstream interrupt controller
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_type_e;

  function automatic edge_type_e classify_edge(input logic prev_level, input logic next_level);
    edge_type_e kind;
    case ({prev_level, next_level})
      2'b01:   kind = EDGE_RISE;
      2'b10:   kind = EDGE_FALL;
      default: kind = EDGE_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/gpio_input_channel.sv
// One pin: synchronizer, optional debounce filter, edge detect and sticky pending flag.
// Debounce logic exists only when GPIO_INPUT_FILTER_DEBOUNCE_EN is defined.
module gpio_input_channel
  import gpio_input_filter_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEFAULT_DEBOUNCE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pad,
  input  logic                      tick,
  input  logic                      filter_en,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_count,
  input  logic                      rise_en,
  input  logic                      fall_en,
  input  logic                      clr,
  output logic                      level,
  output logic                      pending
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_level;
  logic                   level_q, level_d;
  logic                   pending_q, pending_d;
  edge_type_e             edge_kind;
  logic                   rise, fall;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pad};
    sync_level = sync_q[SYNC_STAGES-1];
  end

`ifdef GPIO_INPUT_FILTER_DEBOUNCE_EN
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic [DEBOUNCE_WIDTH:0]   cnt_next;
  logic [DEBOUNCE_WIDTH:0]   threshold;

  // Counter is one bit wider in the compare so it saturates at the threshold instead of wrapping
  always_comb begin
    threshold = (debounce_count == '0) ? (DEBOUNCE_WIDTH+1)'(1) : {1'b0, debounce_count};
    cnt_next  = {1'b0, cnt_q} + (DEBOUNCE_WIDTH+1)'(1);
    level_d   = level_q;
    cnt_d     = cnt_q;
    if (!filter_en) begin
      level_d = sync_level;
      cnt_d   = '0;
    end else if (tick) begin
      if (sync_level == level_q) begin
        cnt_d = '0;
      end else if (cnt_next >= threshold) begin
        level_d = sync_level;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_next[DEBOUNCE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;

  always_comb begin
    level_d    = sync_level;
    unused_cfg = ^{tick, filter_en, debounce_count};
  end
`endif

  // A clear and a new edge in the same cycle leave the flag set
  always_comb begin
    edge_kind = classify_edge(level_q, level_d);
    rise      = (edge_kind == EDGE_RISE);
    fall      = (edge_kind == EDGE_FALL);
    pending_d = (pending_q & ~clr) | (rise & rise_en) | (fall & fall_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  assign level   = level_q;
  assign pending = pending_q;

endmodule

// File: rtl/gpio_input_filter.sv
// Pad-to-GPIO input conditioning: per-pin channels, shared sample prescaler, irq reduction.
// Prescaler and debounce are built only when GPIO_INPUT_FILTER_DEBOUNCE_EN is defined.
module gpio_input_filter
  import gpio_input_filter_pkg::*;
#(
  parameter int IO_COUNT       = DEFAULT_IO_COUNT,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH,
  parameter int DEBOUNCE_WIDTH = DEFAULT_DEBOUNCE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IO_COUNT-1:0]       pad_input,
  input  logic [IO_COUNT-1:0]       filter_enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_count,
  input  logic [IO_COUNT-1:0]       rise_irq_enable,
  input  logic [IO_COUNT-1:0]       fall_irq_enable,
  input  logic [IO_COUNT-1:0]       irq_clear,
  output logic [IO_COUNT-1:0]       gpio_input,
  output logic [IO_COUNT-1:0]       irq_pending,
  output logic                      irq
);

  logic tick;

`ifdef GPIO_INPUT_FILTER_DEBOUNCE_EN
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;

  // Compare with >= so lowering prescale below the running count ticks immediately
  always_comb begin
    tick   = (pcnt_q >= prescale);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`else
  logic unused_prescale;

  always_comb begin
    tick            = 1'b0;
    unused_prescale = ^prescale;
  end
`endif

  for (genvar i = 0; i < IO_COUNT; i++) begin : g_channel
    gpio_input_channel #(
      .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .pad           (pad_input[i]),
      .tick          (tick),
      .filter_en     (filter_enable[i]),
      .debounce_count(debounce_count),
      .rise_en       (rise_irq_enable[i]),
      .fall_en       (fall_irq_enable[i]),
      .clr           (irq_clear[i]),
      .level         (gpio_input[i]),
      .pending       (irq_pending[i])
    );
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Directed self-checking bench for gpio_input_filter; expectations follow the
// build mode selected by GPIO_INPUT_FILTER_DEBOUNCE_EN.
module tb_gpio_input_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pad_input;
  logic [15:0] filter_enable;
  logic [7:0]  prescale;
  logic [3:0]  debounce_count;
  logic [15:0] rise_irq_enable;
  logic [15:0] fall_irq_enable;
  logic [15:0] irq_clear;
  logic [15:0] gpio_input;
  logic [15:0] irq_pending;
  logic        irq;

  int tests_run    = 0;
  int tests_failed = 0;

  // Filter-dependent expectations: accept window for pin 3 and reject result
`ifdef GPIO_INPUT_FILTER_DEBOUNCE_EN
  int  accept_lo        = 15;
  int  accept_hi        = 18;
  int  reject_first     = -1;
  bit  reject_pending   = 1'b0;
  bit  slow_tick_level  = 1'b0;
  bit  filt_hold_level  = 1'b1;
`else
  int  accept_lo        = 3;
  int  accept_hi        = 3;
  int  reject_first     = 3;
  bit  reject_pending   = 1'b1;
  bit  slow_tick_level  = 1'b1;
  bit  filt_hold_level  = 1'b0;
`endif

  gpio_input_filter dut (
    .clk            (clk),
    .rst            (rst),
    .pad_input      (pad_input),
    .filter_enable  (filter_enable),
    .prescale       (prescale),
    .debounce_count (debounce_count),
    .rise_irq_enable(rise_irq_enable),
    .fall_irq_enable(fall_irq_enable),
    .irq_clear      (irq_clear),
    .gpio_input     (gpio_input),
    .irq_pending    (irq_pending),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pending();
    irq_clear = 16'hFFFF;
    step(1);
    irq_clear = 16'h0000;
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    pad_input       = 16'h0001;
    filter_enable   = 16'h0000;
    prescale        = 8'd0;
    debounce_count  = 4'd0;
    rise_irq_enable = 16'h0001;
    fall_irq_enable = 16'h0000;
    irq_clear       = 16'h0000;
    step(2);
    tests_run++;
    if ({gpio_input, irq_pending, irq} !== 33'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: got gpio=%h pend=%h irq=%b, want all 0", gpio_input, irq_pending, irq);
    end
    rst = 1'b1;
    step(2);
    tests_run++;
    if (gpio_input !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_edge2: got gpio=%h, want 0000", gpio_input);
    end
    step(1);
    tests_run++;
    if (gpio_input !== 16'h0001 || irq_pending !== 16'h0001 || irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_edge3: got gpio=%h pend=%h irq=%b, want 0001 0001 1", gpio_input, irq_pending, irq);
    end
    clear_pending();
    tests_run++;
    if (irq_pending !== 16'h0000 || irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_clear: got pend=%h irq=%b, want 0000 0", irq_pending, irq);
    end
  endtask

  task automatic test_debounce_reject();
    int first_high = -1;
    prescale        = 8'd3;
    debounce_count  = 4'd4;
    filter_enable   = 16'h0008;
    rise_irq_enable = 16'h0009;
    fall_irq_enable = 16'h0008;
    step(4);
    pad_input[3] = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      if (i == 13) pad_input[3] = 1'b0;
      step(1);
      if (gpio_input[3] && first_high < 0) first_high = i;
    end
    tests_run++;
    if (first_high != reject_first) begin
      tests_failed++;
      $display("[TB] FAIL reject_level: first high edge %0d, want %0d", first_high, reject_first);
    end
    tests_run++;
    if (irq_pending[3] !== reject_pending || gpio_input[3] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reject_pending: got pend3=%b gpio3=%b, want %b 0", irq_pending[3], gpio_input[3], reject_pending);
    end
    clear_pending();
  endtask

  task automatic test_debounce_accept();
    int first_high = -1;
    int first_low  = -1;
    bit prev_pend  = 1'b0;
    bit pend_before = 1'b1;
    bit pend_at    = 1'b0;
    pad_input[3] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (gpio_input[3] && first_high < 0) first_high = i;
    end
    tests_run++;
    if (first_high < accept_lo || first_high > accept_hi) begin
      tests_failed++;
      $display("[TB] FAIL accept_rise: rose at edge %0d, want %0d..%0d", first_high, accept_lo, accept_hi);
    end
    tests_run++;
    if (irq_pending !== 16'h0008) begin
      tests_failed++;
      $display("[TB] FAIL accept_rise_pend: got pend=%h, want 0008", irq_pending);
    end
    clear_pending();
    pad_input[3] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      prev_pend = irq_pending[3];
      step(1);
      if (!gpio_input[3] && first_low < 0) begin
        first_low   = i;
        pend_at     = irq_pending[3];
        pend_before = prev_pend;
      end
    end
    tests_run++;
    if (first_low < accept_lo || first_low > accept_hi) begin
      tests_failed++;
      $display("[TB] FAIL accept_fall: fell at edge %0d, want %0d..%0d", first_low, accept_lo, accept_hi);
    end
    tests_run++;
    if (pend_at !== 1'b1 || pend_before !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL accept_fall_pend: got before=%b at=%b, want 0 1", pend_before, pend_at);
    end
    clear_pending();
  endtask

  task automatic test_clear_race();
    rise_irq_enable = 16'h0029;
    pad_input[5]    = 1'b1;
    step(2);
    irq_clear = 16'h0020;
    step(1);
    irq_clear = 16'h0000;
    tests_run++;
    if (irq_pending[5] !== 1'b1 || gpio_input[5] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clear_race: got pend5=%b gpio5=%b, want 1 1", irq_pending[5], gpio_input[5]);
    end
    irq_clear = 16'h0020;
    step(1);
    irq_clear = 16'h0000;
    tests_run++;
    if (irq_pending !== 16'h0000 || irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_second: got pend=%h irq=%b, want 0000 0", irq_pending, irq);
    end
    fall_irq_enable = 16'h0028;
    pad_input[5]    = 1'b0;
    step(3);
    fall_irq_enable = 16'h0008;
    step(2);
    tests_run++;
    if (irq_pending !== 16'h0020 || irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL enable_drop_keeps: got pend=%h irq=%b, want 0020 1", irq_pending, irq);
    end
    clear_pending();
  endtask

  task automatic test_mid_changes();
    filter_enable  = 16'h0008;
    debounce_count = 4'd1;
    prescale       = 8'd200;
    step(10);
    pad_input[3] = 1'b1;
    step(4);
    tests_run++;
    if (gpio_input[3] !== slow_tick_level) begin
      tests_failed++;
      $display("[TB] FAIL slow_prescale: got gpio3=%b, want %b", gpio_input[3], slow_tick_level);
    end
    prescale = 8'd0;
    step(1);
    tests_run++;
    if (gpio_input[3] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL prescale_drop_tick: got gpio3=%b, want 1", gpio_input[3]);
    end
    clear_pending();
    prescale       = 8'd50;
    debounce_count = 4'd4;
    pad_input[3]   = 1'b0;
    step(5);
    tests_run++;
    if (gpio_input[3] !== filt_hold_level) begin
      tests_failed++;
      $display("[TB] FAIL filter_hold: got gpio3=%b, want %b", gpio_input[3], filt_hold_level);
    end
    filter_enable = 16'h0000;
    step(1);
    tests_run++;
    if (gpio_input[3] !== 1'b0 || irq_pending[3] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL filter_drop: got gpio3=%b pend3=%b, want 0 1", gpio_input[3], irq_pending[3]);
    end
    filter_enable = 16'h0008;
    pad_input[3]  = 1'b1;
    step(5);
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({gpio_input, irq_pending, irq} !== 33'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got gpio=%h pend=%h irq=%b, want all 0", gpio_input, irq_pending, irq);
    end
    step(1);
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_debounce_reject();
    test_debounce_accept();
    test_clear_race();
    test_mid_changes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
